// File: rtl/nx_mesh_trigger_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nx_mesh_trigger_ctrl_pkg
// Brief    : Shared types and defaults for the mesh trigger controller.
// Revision : 1.0 - initial release
// ============================================================================
package nx_mesh_trigger_ctrl_pkg;

  // Mesh scheduler states
  typedef enum logic [1:0] {
    STOPPED   = 2'd0,
    WAIT_IDLE = 2'd1,
    TRIGGER   = 2'd2,
    SETTLE    = 2'd3
  } mesh_ctrl_state_t;

  // Defaults: mesh idle must hold two registered cycles, and two cycles
  // after each trigger are ignored to cover node idle-register lag.
  localparam int unsigned DEFAULT_IDLE_STABLE   = 2;
  localparam int unsigned DEFAULT_SETTLE_CYCLES = 2;

  // Bits needed for a counter that runs 0..n-1 (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nx_mesh_idle_filter.sv
`default_nettype none
// ============================================================================
// Module   : nx_mesh_idle_filter
// Brief    : Registers the AND of all node idle flags and reports when that
//            registered idle has held for IDLE_STABLE consecutive cycles.
// Revision : 1.0 - initial release
// ============================================================================
module nx_mesh_idle_filter
  import nx_mesh_trigger_ctrl_pkg::*;
#(
  parameter int unsigned NODES       = 9,
  parameter int unsigned IDLE_STABLE = DEFAULT_IDLE_STABLE
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NODES-1:0] i_node_idle,
  input  logic             i_clear,
  output logic             o_mesh_idle,
  output logic             o_idle_stable
);

  localparam int unsigned            CNT_W       = cnt_width(IDLE_STABLE);
  localparam logic [CNT_W-1:0]       STABLE_LAST = CNT_W'(IDLE_STABLE - 1);

  logic             idle_d, idle_q;
  logic [CNT_W-1:0] stable_cnt_d, stable_cnt_q;

  // Next idle sample and stability count; the count saturates at its last
  // value so a held window keeps reporting stable until cleared.
  always_comb begin
    idle_d       = &i_node_idle;
    stable_cnt_d = stable_cnt_q;
    if (i_clear || !idle_q) begin
      stable_cnt_d = '0;
    end else if (stable_cnt_q != STABLE_LAST) begin
      stable_cnt_d = stable_cnt_q + CNT_W'(1);
    end
  end

  // Idle and stability registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idle_q       <= 1'b0;
      stable_cnt_q <= '0;
    end else begin
      idle_q       <= idle_d;
      stable_cnt_q <= stable_cnt_d;
    end
  end

  assign o_mesh_idle   = idle_q;
  assign o_idle_stable = idle_q && (stable_cnt_q == STABLE_LAST);

endmodule
`default_nettype wire

// File: rtl/nx_mesh_trigger_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nx_mesh_trigger_ctrl
// Brief    : Mesh-level scheduler. Accepts a run of N cycles, waits for a
//            stable idle mesh, broadcasts one-cycle triggers and reports done
//            once the mesh has drained after the last trigger or a stop.
// Revision : 1.0 - initial release
// ============================================================================
module nx_mesh_trigger_ctrl
  import nx_mesh_trigger_ctrl_pkg::*;
#(
  parameter int unsigned ROWS          = 3,
  parameter int unsigned COLUMNS       = 3,
  parameter int unsigned CYCLE_W       = 24,
  parameter int unsigned IDLE_STABLE   = DEFAULT_IDLE_STABLE,
  parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_run_valid,
  input  logic [CYCLE_W-1:0]      i_run_cycles,
  output logic                    o_run_ready,
  input  logic                    i_stop,
  input  logic [ROWS*COLUMNS-1:0] i_node_idle,
  output logic                    o_trigger,
  output logic                    o_active,
  output logic                    o_done,
  output logic                    o_mesh_idle,
  output logic [CYCLE_W-1:0]      o_cycle_count
);

  localparam int unsigned      SET_W       = cnt_width(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  mesh_ctrl_state_t   state_d, state_q;
  logic [CYCLE_W-1:0] remaining_d, remaining_q;
  logic [CYCLE_W-1:0] count_d, count_q;
  logic [SET_W-1:0]   settle_cnt_d, settle_cnt_q;
  logic               done_d, done_q;
  logic               idle_stable;
  logic               filter_clear;

  // Stability window only runs in WAIT_IDLE, so every entry starts from zero
  assign filter_clear = (state_q != WAIT_IDLE);

  nx_mesh_idle_filter #(
    .NODES       (ROWS * COLUMNS),
    .IDLE_STABLE (IDLE_STABLE)
  ) u_idle_filter (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_node_idle   (i_node_idle),
    .i_clear       (filter_clear),
    .o_mesh_idle   (o_mesh_idle),
    .o_idle_stable (idle_stable)
  );

  // Next-state, remaining/cycle counters and done pulse
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    count_d      = count_q;
    settle_cnt_d = settle_cnt_q;
    done_d       = 1'b0;
    case (state_q)
      STOPPED: begin
        if (i_run_valid) begin
          if (i_run_cycles == '0) begin
            done_d = 1'b1;
          end else begin
            remaining_d = i_run_cycles;
            state_d     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (i_stop) begin
          remaining_d = '0;
        end
        if (idle_stable) begin
          if (remaining_q == '0) begin
            state_d = STOPPED;
            done_d  = 1'b1;
          end else if (!i_stop) begin
            // A stop arriving with the window met holds here; the next
            // cycle sees remaining==0 and finishes the drain.
            state_d = TRIGGER;
          end
        end
      end
      TRIGGER: begin
        remaining_d  = i_stop ? '0 : (remaining_q - CYCLE_W'(1));
        count_d      = count_q + CYCLE_W'(1);
        settle_cnt_d = '0;
        state_d      = SETTLE;
      end
      SETTLE: begin
        if (i_stop) begin
          remaining_d = '0;
        end
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = WAIT_IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end
      default: state_d = STOPPED;
    endcase
  end

  // Controller registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= STOPPED;
      remaining_q  <= '0;
      count_q      <= '0;
      settle_cnt_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      count_q      <= count_d;
      settle_cnt_q <= settle_cnt_d;
      done_q       <= done_d;
    end
  end

  assign o_run_ready   = (state_q == STOPPED);
  assign o_active      = (state_q != STOPPED);
  assign o_trigger     = (state_q == TRIGGER);
  assign o_done        = done_q;
  assign o_cycle_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_nx_mesh_trigger_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nx_mesh_trigger_ctrl
// Brief    : Scoreboard bench for nx_mesh_trigger_ctrl. Directed runs push
//            expected trigger/done events (cycle and cycle count); a monitor
//            pops and compares whenever the DUT pulses o_trigger or o_done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nx_mesh_trigger_ctrl;

  localparam int CW    = 8;
  localparam int NODES = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             run_valid;
  logic [CW-1:0]    run_cycles;
  logic             run_ready;
  logic             stop;
  logic [NODES-1:0] node_idle;
  logic             trigger;
  logic             active;
  logic             done;
  logic             mesh_idle;
  logic [CW-1:0]    cycle_count;

  nx_mesh_trigger_ctrl #(
    .ROWS          (3),
    .COLUMNS       (3),
    .CYCLE_W       (CW),
    .IDLE_STABLE   (2),
    .SETTLE_CYCLES (2)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_run_valid   (run_valid),
    .i_run_cycles  (run_cycles),
    .o_run_ready   (run_ready),
    .i_stop        (stop),
    .i_node_idle   (node_idle),
    .o_trigger     (trigger),
    .o_active      (active),
    .o_done        (done),
    .o_mesh_idle   (mesh_idle),
    .o_cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  // Cycle number: increments on every rising edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_done;
    int            at_cyc;
    logic [CW-1:0] count;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic push_ev(input bit is_done, input int at_cyc, input int count);
    ev_t e;
    e.is_done = is_done;
    e.at_cyc  = at_cyc;
    e.count   = CW'(count);
    sb.push_back(e);
  endtask

  // Continuously idle mesh: triggers at c+3+5k, done 5 cycles after the last
  task automatic push_run(input int c, input int n, input int base);
    for (int k = 0; k < n; k++) push_ev(1'b0, c + 3 + 5 * k, base + k);
    push_ev(1'b1, c + 3 + 5 * (n - 1) + 5, base + n);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cycle(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Present a request at the current negedge; the rising edge that follows
  // accepts it, so this cycle number is the acceptance cycle.
  task automatic present(input int n, output int c);
    run_valid  = 1'b1;
    run_cycles = CW'(n);
    c          = cyc;
    check("run_ready_at_request", int'(run_ready), 1);
  endtask

  task automatic release_req();
    @(negedge clk);
    run_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int b;
    b = budget;
    while (sb.size() != 0 && b > 0) begin
      @(negedge clk);
      b--;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout: %0d events outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every trigger/done pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (trigger || done) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: trigger=%0b done=%0b count=%0d at cycle %0d, required no event",
                 trigger, done, cycle_count, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_done != done || mon_e.is_done == trigger ||
            mon_e.at_cyc != cyc || mon_e.count != cycle_count) begin
          n_bad++;
          $display("FAIL event: got done=%0b trigger=%0b cycle=%0d count=%0d, required done=%0b cycle=%0d count=%0d",
                   done, trigger, cyc, cycle_count, mon_e.is_done, mon_e.at_cyc, mon_e.count);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int c, c2;

  initial begin
    rst        = 1'b1;
    run_valid  = 1'b1;      // request held during reset must be ignored
    run_cycles = CW'(3);
    stop       = 1'b0;
    node_idle  = '1;
    repeat (3) @(negedge clk);
    check("reset_run_ready", int'(run_ready), 1);
    check("reset_active", int'(active), 0);
    check("reset_trigger", int'(trigger), 0);
    check("reset_done", int'(done), 0);
    check("reset_mesh_idle", int'(mesh_idle), 0);
    check("reset_cycle_count", int'(cycle_count), 0);
    rst       = 1'b0;
    run_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_after_reset_active", int'(active), 0);
    check("mesh_idle_registered", int'(mesh_idle), 1);

    // Run 3, mesh continuously idle
    present(3, c);
    push_run(c, 3, 0);
    release_req();
    check("run3_active_start", int'(active), 1);
    check("run3_ready_busy", int'(run_ready), 0);
    wait_cycle(c + 17);
    check("run3_active_last", int'(active), 1);
    wait_cycle(c + 18);
    check("run3_active_done", int'(active), 0);
    check("run3_ready_done", int'(run_ready), 1);
    drain("run3", 40);

    // Run 0: done next cycle, nothing else
    repeat (2) @(negedge clk);
    present(0, c);
    push_ev(1'b1, c + 1, 3);
    release_req();
    check("run0_active", int'(active), 0);
    repeat (6) @(negedge clk);
    check("run0_active_later", int'(active), 0);
    check("run0_count", int'(cycle_count), 3);
    drain("run0", 10);

    // Run 2 with node 4 busy after the first trigger, one 1-cycle idle blip
    present(2, c);
    push_ev(1'b0, c + 3, 3);
    push_ev(1'b0, c + 17, 4);
    push_ev(1'b1, c + 22, 5);
    release_req();
    wait_cycle(c + 3);
    for (int i = 0; i < 11; i++) begin
      node_idle = (i == 5) ? 9'h1FF : 9'h1EF;
      @(negedge clk);
    end
    node_idle = '1;
    check("blip_mesh_idle_low_check", int'(active), 1);
    drain("busy_node", 40);

    // Run 100, stop during SETTLE after the 2nd trigger, then a new request
    repeat (2) @(negedge clk);
    present(100, c);
    push_ev(1'b0, c + 3, 5);
    push_ev(1'b0, c + 8, 6);
    push_ev(1'b1, c + 13, 7);
    release_req();
    wait_cycle(c + 9);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_cycle(c + 13);
    present(0, c2);
    check("stop_reissue_cycle", c2, c + 13);
    push_ev(1'b1, c2 + 1, 7);
    release_req();
    drain("stop", 40);

    // Run 5, reset after the 2nd trigger
    repeat (2) @(negedge clk);
    present(5, c);
    push_ev(1'b0, c + 3, 7);
    push_ev(1'b0, c + 8, 8);
    release_req();
    wait_cycle(c + 9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_ready", int'(run_ready), 1);
    check("midreset_active", int'(active), 0);
    check("midreset_count", int'(cycle_count), 0);
    check("midreset_done", int'(done), 0);
    repeat (15) @(negedge clk);
    check("midreset_still_stopped", int'(active), 0);
    drain("midreset", 5);

    // Run 255 to bring the count to the top, then run 2 across the wrap
    present(255, c);
    push_run(c, 255, 0);
    release_req();
    wait_cycle(c + 1278);
    present(2, c2);
    push_ev(1'b0, c2 + 3, 255);
    push_ev(1'b0, c2 + 8, 0);
    push_ev(1'b1, c2 + 13, 1);
    release_req();
    drain("wrap", 1400);
    check("wrap_final_count", int'(cycle_count), 1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
